// File: rtl/dbg_pkg.sv
// Shared definitions for the core-side debug step controller.
//   dbg_state_e : controller state (HALT, STEP, SCAN, RUN)
//   NUM_REGS    : architectural registers mirrored in the snapshot
//   REG_AW      : register-file address width
//   XLEN_DEF    : default data/PC width
package dbg_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        SCAN = 2'd2,
        RUN  = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/dbg_edge_sync.sv
// Synchronises the asynchronous step-request level into the core clock
// domain and reports its rising edges.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_level : raw step-request level
//   o_rise  : one-cycle pulse on each synchronised rising edge
module dbg_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/dbg_step_ctrl.sv
// Core-side end of the JTAG debug link. Converts step requests into core
// clock-enable bursts, free-runs the core on request, and while the core is
// halted scans x1..x31 through a spare register-file read port into a stable
// snapshot together with the PC.
//   dbg_clk_clk       : clock
//   dbg_reset_reset_n : synchronous active-low reset
//   dbg_clock_export  : step request level, each rising edge = one step
//   dbg_run_i         : 1 = free-run, 0 = halt/step mode
//   core_pc_i         : current core PC
//   rf_rdata_i        : spare read-port data (RF_LAT cycles after address)
//   rf_raddr_o        : spare read-port address (0 outside a scan)
//   core_ce_o         : core clock enable
//   dbg_pc_export     : snapshot PC
//   dbg_regs_export   : snapshot x0..x31, xN at [N*XLEN +: XLEN], x0 = 0
//   dbg_snap_valid_o  : snapshot complete and consistent
//   dbg_step_cnt_o    : steps issued since reset (wraps)
//   dbg_step_drop_o   : sticky, a step request was dropped
module dbg_step_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned RF_LAT      = 1
) (
    input  logic                     dbg_clk_clk,
    input  logic                     dbg_reset_reset_n,
    input  logic                     dbg_clock_export,
    input  logic                     dbg_run_i,
    input  logic [XLEN-1:0]          core_pc_i,
    input  logic [XLEN-1:0]          rf_rdata_i,
    output logic [REG_AW-1:0]        rf_raddr_o,
    output logic                     core_ce_o,
    output logic [XLEN-1:0]          dbg_pc_export,
    output logic [NUM_REGS*XLEN-1:0] dbg_regs_export,
    output logic                     dbg_snap_valid_o,
    output logic [31:0]              dbg_step_cnt_o,
    output logic                     dbg_step_drop_o
);

    localparam logic [5:0] STEP_LAST = 6'(STEP_CYCLES - 1);
    localparam logic [5:0] ADDR_LAST = 6'(NUM_REGS - 2);
    localparam logic [5:0] RD_FIRST  = 6'(RF_LAT);
    localparam logic [5:0] SCAN_LAST = 6'(NUM_REGS - 2 + RF_LAT);

    dbg_state_e      r_state;
    logic [5:0]      r_cnt;
    logic            r_pending;
    logic            r_drop;
    logic            r_valid;
    logic [31:0]     r_step_cnt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_regs [1:NUM_REGS-1];

    logic              w_rise;
    logic [REG_AW-1:0] w_wr_idx;

    dbg_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (dbg_clk_clk),
        .i_rst_n (dbg_reset_reset_n),
        .i_level (dbg_clock_export),
        .o_rise  (w_rise)
    );

    // Data returning in scan cycle k belongs to the address issued at k-RF_LAT.
    assign w_wr_idx = r_cnt[REG_AW-1:0] + REG_AW'(1) - REG_AW'(RF_LAT);

    always_ff @(posedge dbg_clk_clk) begin
        if (!dbg_reset_reset_n) begin
            r_state    <= SCAN;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_drop     <= 1'b0;
            r_valid    <= 1'b0;
            r_step_cnt <= '0;
            r_pc       <= '0;
            for (int unsigned n = 1; n < NUM_REGS; n++) r_regs[n] <= '0;
        end else begin
            case (r_state)
                HALT: begin
                    if (dbg_run_i) begin
                        r_state <= RUN;
                    end else if (w_rise || r_pending) begin
                        r_state    <= STEP;
                        r_cnt      <= '0;
                        r_pending  <= r_pending & w_rise;
                        r_step_cnt <= r_step_cnt + 32'd1;
                        r_valid    <= 1'b0;
                    end
                end
                STEP: begin
                    if (w_rise) begin
                        if (r_pending) r_drop <= 1'b1;
                        else           r_pending <= 1'b1;
                    end
                    if (r_cnt == STEP_LAST) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                SCAN: begin
                    if (r_cnt == '0)      r_pc <= core_pc_i;
                    if (r_cnt >= RD_FIRST) r_regs[w_wr_idx] <= rf_rdata_i;
                    // A queued step is taken straight from the last scan cycle,
                    // so the core never idles in HALT between back-to-back steps.
                    if (r_cnt == SCAN_LAST && !dbg_run_i && (r_pending || w_rise)) begin
                        r_state    <= STEP;
                        r_cnt      <= '0;
                        r_pending  <= r_pending & w_rise;
                        r_step_cnt <= r_step_cnt + 32'd1;
                    end else begin
                        if (w_rise) begin
                            if (r_pending) r_drop <= 1'b1;
                            else           r_pending <= 1'b1;
                        end
                        if (r_cnt == SCAN_LAST) begin
                            r_state <= HALT;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                RUN: begin
                    r_valid <= 1'b0;
                    if (!dbg_run_i) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign core_ce_o  = (r_state == STEP) || (r_state == RUN);
    assign rf_raddr_o = (r_state == SCAN && r_cnt <= ADDR_LAST) ?
                        r_cnt[REG_AW-1:0] + REG_AW'(1) : '0;

    always_comb begin
        dbg_regs_export = '0;
        for (int unsigned n = 1; n < NUM_REGS; n++)
            dbg_regs_export[n*XLEN +: XLEN] = r_regs[n];
    end

    assign dbg_pc_export    = r_pc;
    assign dbg_snap_valid_o = r_valid;
    assign dbg_step_cnt_o   = r_step_cnt;
    assign dbg_step_drop_o  = r_drop;

endmodule
